// File: rtl/d_drain_arbiter.sv
// Round-robin drain of destination FIFOs D0/D1 into a 2-entry output buffer with valid/ready output.
// Optional per-source delivery counters are built only when D_DRAIN_STATS_EN is defined.
module d_drain_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active_in,
    input  logic                  empty_D0,
    input  logic                  empty_D1,
    input  logic [DATA_WIDTH-1:0] data_D0,
    input  logic [DATA_WIDTH-1:0] data_D1,
    output logic                  D0_pop,
    output logic                  D1_pop,
    input  logic                  out_ready,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  dest_out,
    output logic [CNT_WIDTH-1:0]  cnt_D0,
    output logic [CNT_WIDTH-1:0]  cnt_D1
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_src_q, inflight_src_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic                  src0_q, src0_d, src1_q, src1_d;

    logic                  transfer;
    logic                  pop_ok;
    logic                  pop_any;
    logic                  pop_sel;
    logic [1:0]            pending;
    logic [1:0]            occ_after;
    logic [DATA_WIDTH-1:0] wr_dat;

    assign valid_out = (occ_q != 2'd0);
    assign data_out  = dat0_q;
    assign dest_out  = src0_q;
    assign transfer  = valid_out && out_ready;
    assign pending   = occ_q + {1'b0, inflight_q};
    assign wr_dat    = inflight_src_q ? data_D1 : data_D0;

    // A pop is allowed only if its word is guaranteed a buffer slot when it lands next cycle.
    always_comb begin
        pop_ok  = !reset && (state_q == RUN) &&
                  ((pending < 2'd2) || ((pending == 2'd2) && transfer));
        pop_any = pop_ok && (!empty_D0 || !empty_D1);
        if (!empty_D0 && !empty_D1) begin
            pop_sel = ~last_q;
        end else begin
            pop_sel = empty_D0;
        end
        D0_pop = pop_any && !pop_sel;
        D1_pop = pop_any && pop_sel;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (active_in) state_d = RUN;
            RUN:     if (!active_in) state_d = FLUSH;
            FLUSH: begin
                if (active_in) begin
                    state_d = RUN;
                end else if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d     = pop_any;
        inflight_src_d = pop_sel;
        last_d         = pop_any ? pop_sel : last_q;

        dat0_d    = dat0_q;
        src0_d    = src0_q;
        dat1_d    = dat1_q;
        src1_d    = src1_q;
        occ_after = occ_q - {1'b0, transfer};
        if (transfer) begin
            dat0_d = dat1_q;
            src0_d = src1_q;
        end
        // Returned word goes to the first free slot after this cycle's removal.
        if (inflight_q) begin
            if (occ_after == 2'd0) begin
                dat0_d = wr_dat;
                src0_d = inflight_src_q;
            end else begin
                dat1_d = wr_dat;
                src1_d = inflight_src_q;
            end
            occ_d = occ_after + 2'd1;
        end else begin
            occ_d = occ_after;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            occ_q          <= 2'd0;
            inflight_q     <= 1'b0;
            inflight_src_q <= 1'b0;
            last_q         <= 1'b1;
            dat0_q         <= '0;
            src0_q         <= 1'b0;
            dat1_q         <= '0;
            src1_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            occ_q          <= occ_d;
            inflight_q     <= inflight_d;
            inflight_src_q <= inflight_src_d;
            last_q         <= last_d;
            dat0_q         <= dat0_d;
            src0_q         <= src0_d;
            dat1_q         <= dat1_d;
            src1_q         <= src1_d;
        end
    end

`ifdef D_DRAIN_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_d0_q, cnt_d0_d;
    logic [CNT_WIDTH-1:0] cnt_d1_q, cnt_d1_d;

    always_comb begin
        cnt_d0_d = cnt_d0_q;
        cnt_d1_d = cnt_d1_q;
        if (transfer && !src0_q) cnt_d0_d = cnt_d0_q + 1'b1;
        if (transfer && src0_q)  cnt_d1_d = cnt_d1_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
        end
    end

    assign cnt_D0 = cnt_d0_q;
    assign cnt_D1 = cnt_d1_q;
`else
    assign cnt_D0 = '0;
    assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_d_drain_arbiter.sv
// Scoreboard bench for d_drain_arbiter: FIFO models feed the DUT, a negedge monitor checks every transfer,
// round-robin choice and counters against a queue-based reference model.
module tb_d_drain_arbiter;
    localparam int DW = 6;
    localparam int CW = 8;
`ifdef D_DRAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic          src;
        logic [DW-1:0] dat;
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          active_in = 1'b1;
    logic          empty_D0 = 1'b1;
    logic          empty_D1 = 1'b1;
    logic [DW-1:0] data_D0 = '0;
    logic [DW-1:0] data_D1 = '0;
    logic          D0_pop, D1_pop;
    logic          out_ready = 1'b1;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          dest_out;
    logic [CW-1:0] cnt_D0, cnt_D1;

    always #5 clk = ~clk;

    d_drain_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .active_in(active_in),
        .empty_D0(empty_D0), .empty_D1(empty_D1),
        .data_D0(data_D0), .data_D1(data_D1),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .out_ready(out_ready), .valid_out(valid_out),
        .data_out(data_out), .dest_out(dest_out),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1)
    );

    logic [DW-1:0] src_q0[$];
    logic [DW-1:0] src_q1[$];
    int            rd0 = 0;
    int            rd1 = 0;
    word_t         expq[$];
    int            pop_cyc[$];
    logic          pop_src_log[$];
    int            xfer_cyc[$];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            nprint = 0;

    function automatic void chk(string name, logic ok, logic [31:0] act, logic [31:0] req);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            if (nprint < 60) begin
                nprint++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
            end
        end
    endfunction

    task automatic refresh();
        empty_D0 = (src_q0.size() == rd0);
        empty_D1 = (src_q1.size() == rd1);
    endtask

    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            refresh();
        end
    endtask

    // Monitor: reference model of FIFO read-out, output order, round-robin and counters.
    initial begin : monitor
        logic          last_m;
        logic [CW-1:0] cm0, cm1;
        logic          prev_stall;
        word_t         prev_w;
        logic          pend0_v, pend1_v;
        logic [DW-1:0] pend0, pend1;
        word_t         w;
        logic          src, exp_src;
        last_m = 1'b1; cm0 = '0; cm1 = '0; prev_stall = 1'b0; prev_w = '0;
        pend0 = '0; pend1 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            pend0_v = 1'b0;
            pend1_v = 1'b0;
            if (reset) begin
                expq.delete();
                last_m = 1'b1; cm0 = '0; cm1 = '0; prev_stall = 1'b0;
                chk("pop_in_reset", !D0_pop && !D1_pop, {30'd0, D1_pop, D0_pop}, 32'd0);
            end else begin
                chk("counters", (cnt_D0 == cm0) && (cnt_D1 == cm1),
                    {16'd0, cnt_D1, cnt_D0}, {16'd0, cm1, cm0});
                if (prev_stall)
                    chk("stall_hold", valid_out && ({dest_out, data_out} == prev_w),
                        {24'd0, valid_out, dest_out, data_out}, {24'd0, 1'b1, prev_w});
                if (valid_out && out_ready) begin
                    xfer_cyc.push_back(cyc);
                    if (expq.size() == 0) begin
                        chk("sb_underrun", 1'b0, {25'd0, dest_out, data_out}, 32'd0);
                    end else begin
                        w = expq.pop_front();
                        chk("sb_word", {dest_out, data_out} == w, {25'd0, dest_out, data_out}, {25'd0, w});
                        if (STATS) begin
                            if (w.src) cm1 = cm1 + 1'b1;
                            else       cm0 = cm0 + 1'b1;
                        end
                    end
                end
                prev_stall = valid_out && !out_ready;
                prev_w     = {dest_out, data_out};
                if (D0_pop || D1_pop) begin
                    src     = D1_pop;
                    exp_src = (!empty_D0 && !empty_D1) ? !last_m : empty_D0;
                    chk("rr_pick", !(D0_pop && D1_pop) && (src == exp_src) && !(src ? empty_D1 : empty_D0),
                        {30'd0, D1_pop, D0_pop}, {31'd0, exp_src});
                    last_m = src;
                    pop_cyc.push_back(cyc);
                    pop_src_log.push_back(src);
                    if (!src && rd0 < src_q0.size()) begin
                        pend0 = src_q0[rd0]; rd0++; pend0_v = 1'b1;
                        expq.push_back({1'b0, pend0});
                    end
                    if (src && rd1 < src_q1.size()) begin
                        pend1 = src_q1[rd1]; rd1++; pend1_v = 1'b1;
                        expq.push_back({1'b1, pend1});
                    end
                end
            end
            @(posedge clk);
            #1;
            data_D0 = pend0_v ? pend0 : DW'($urandom);
            data_D1 = pend1_v ? pend1 : DW'($urandom);
        end
    end

    initial begin : stimulus
        int            bp, bx, n0, n1;
        logic          alt_ok;
        logic [CW-1:0] exp_c1;
        // Reset held with both FIFOs loaded and drain enabled.
        for (int i = 0; i < 8; i++) begin
            src_q0.push_back(6'b000101);
            src_q1.push_back(6'b110110);
        end
        refresh();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_pop", !D0_pop && !D1_pop, {30'd0, D1_pop, D0_pop}, 32'd0);
            chk("rst_valid", valid_out == 1'b0, {31'd0, valid_out}, 32'd0);
            chk("rst_cnt", (cnt_D0 == 0) && (cnt_D1 == 0), {16'd0, cnt_D1, cnt_D0}, 32'd0);
            chk("rst_out", (data_out == 0) && (dest_out == 0), {25'd0, dest_out, data_out}, 32'd0);
        end
        reset = 1'b0;
        bp = pop_cyc.size();
        bx = xfer_cyc.size();
        step(24);
        chk("alt_xfers", xfer_cyc.size() - bx == 16, xfer_cyc.size() - bx, 16);
        if (xfer_cyc.size() - bx >= 16 && pop_cyc.size() - bp >= 16) begin
            chk("first_latency", xfer_cyc[bx] - pop_cyc[bp] == 2, xfer_cyc[bx] - pop_cyc[bp], 2);
            chk("one_per_cycle", xfer_cyc[bx+15] - xfer_cyc[bx] == 15, xfer_cyc[bx+15] - xfer_cyc[bx], 15);
            alt_ok = 1'b1;
            for (int i = 0; i < 16; i++) if (pop_src_log[bp+i] != i[0]) alt_ok = 1'b0;
            chk("alternation", alt_ok, {31'd0, alt_ok}, 1);
        end else begin
            chk("alt_count", 1'b0, pop_cyc.size() - bp, 16);
        end

        // Output stalled for 5 cycles: exactly two pops fill the buffer.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            src_q0.push_back(DW'($urandom));
            src_q1.push_back(DW'($urandom));
        end
        refresh();
        bp = pop_cyc.size();
        step(5);
        chk("stall_pops", pop_cyc.size() - bp == 2, pop_cyc.size() - bp, 2);
        chk("stall_valid", valid_out == 1'b1, {31'd0, valid_out}, 1);
        out_ready = 1'b1;
        step(30);
        chk("stall_drain", expq.size() == 0 && rd0 == src_q0.size() && rd1 == src_q1.size(),
            expq.size(), 0);

        // Only D1 holds data, counters checked from a fresh reset.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) src_q1.push_back(DW'($urandom));
        refresh();
        bp = pop_cyc.size();
        step(12);
        n0 = 0; n1 = 0;
        for (int i = bp; i < pop_cyc.size(); i++) begin
            if (pop_src_log[i]) n1++;
            else                n0++;
        end
        chk("d1_only_pops", n1 == 4 && n0 == 0, {n1[15:0], n0[15:0]}, {16'd4, 16'd0});
        if (pop_cyc.size() - bp >= 4)
            chk("d1_consecutive", pop_cyc[bp+3] - pop_cyc[bp] == 3, pop_cyc[bp+3] - pop_cyc[bp], 3);
        exp_c1 = STATS ? CW'(4) : CW'(0);
        chk("d1_cnt", cnt_D1 == exp_c1, {24'd0, cnt_D1}, {24'd0, exp_c1});

        // Drain enable drops with one word buffered and one in flight.
        out_ready = 1'b0;
        src_q0.push_back(DW'($urandom));
        src_q0.push_back(DW'($urandom));
        refresh();
        bp = pop_cyc.size();
        bx = xfer_cyc.size();
        for (int i = 0; i < 10 && pop_cyc.size() < bp + 2; i++) step();
        chk("flush_prepops", pop_cyc.size() == bp + 2, pop_cyc.size() - bp, 2);
        active_in = 1'b0;
        for (int i = 0; i < 3; i++) src_q0.push_back(DW'($urandom));
        refresh();
        step(6);
        chk("flush_no_pop", pop_cyc.size() == bp + 2, pop_cyc.size() - bp, 2);
        out_ready = 1'b1;
        step(4);
        chk("flush_delivered", xfer_cyc.size() - bx == 2 && expq.size() == 0, xfer_cyc.size() - bx, 2);
        chk("flush_idle_out", valid_out == 1'b0, {31'd0, valid_out}, 0);

        // Randomized traffic, enable and backpressure.
        for (int i = 0; i < 1500; i++) begin
            active_in = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) src_q0.push_back(DW'($urandom));
            if ($urandom_range(0, 2) == 0) src_q1.push_back(DW'($urandom));
            refresh();
            step();
        end
        active_in = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (rd0 == src_q0.size() && rd1 == src_q1.size() && expq.size() == 0 && !valid_out) break;
            step();
        end
        chk("rand_drain", rd0 == src_q0.size() && rd1 == src_q1.size() && expq.size() == 0,
            expq.size(), 0);

        // 256 D0 transfers wrap the D0 counter back to zero.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) src_q0.push_back(DW'($urandom));
        refresh();
        bx = xfer_cyc.size();
        for (int i = 0; i < 600 && xfer_cyc.size() - bx < 256; i++) step();
        step();
        chk("wrap_count", xfer_cyc.size() - bx == 256, xfer_cyc.size() - bx, 256);
        chk("wrap_cnt", cnt_D0 == 0 && cnt_D1 == 0, {16'd0, cnt_D1, cnt_D0}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/d_drain_arbiter.md
D_DRAIN_ARBITER -- requirements
Module: d_drain_arbiter

Interface
- REQ-001 Parameter: DATA_WIDTH, default 6, width of every data word.
- REQ-002 Parameter: CNT_WIDTH, default 8, width of each statistics counter.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 active_in  input  1  drain enable from the transmit-layer control FSM (its active output).
- REQ-006 empty_D0, empty_D1  input  1 each  empty flags of destination FIFOs D0/D1.
- REQ-007 data_D0, data_D1  input  DATA_WIDTH each  FIFO read data, valid the cycle after the matching pop.
- REQ-008 D0_pop, D1_pop  output  1 each  FIFO read strobes; mutually exclusive.
- REQ-009 out_ready  input  1  downstream accepts the word on data_out this cycle.
- REQ-010 valid_out  output  1  data_out/dest_out hold a valid word.
- REQ-011 data_out  output  DATA_WIDTH  drained word.
- REQ-012 dest_out  output  1  source of data_out: 0 = D0, 1 = D1.
- REQ-013 cnt_D0, cnt_D1  output  CNT_WIDTH each  words delivered from D0/D1.

Function
- REQ-014 The block SHALL hold a 2-entry FIFO output buffer (word + source bit); valid_out = occupancy > 0; data_out/dest_out = head entry.
- REQ-015 A transfer SHALL complete when valid_out && out_ready; the head is removed at that edge.
- REQ-016 Pop SHALL be combinational from registered state and current inputs; data returned one cycle later SHALL be written into the buffer at the edge ending that cycle.
- REQ-017 inflight SHALL be a register set at the edge ending a pop cycle and cleared otherwise.
- REQ-018 Pop SHALL be permitted only if state = RUN and (occupancy + inflight < 2, or occupancy + inflight = 2 with a transfer this cycle).
- REQ-019 Source selection SHALL be round-robin: both non-empty -> pop the source not last popped; one non-empty -> pop it; both empty -> no pop.
- REQ-020 The last-popped pointer SHALL update only on an actual pop.
- REQ-021 A simultaneous buffer write and transfer SHALL leave occupancy unchanged; the buffer SHALL never overflow or drop a word.
- REQ-022 FSM states: IDLE, RUN, FLUSH.
- REQ-023 IDLE -> RUN when active_in = 1; no pops in IDLE.
- REQ-024 RUN -> FLUSH when active_in = 0; no new pops in FLUSH.
- REQ-025 FLUSH -> IDLE when inflight = 0 and occupancy = 0; FLUSH -> RUN if active_in returns to 1 first.
- REQ-026 Maximum throughput SHALL be one word per cycle with out_ready held high; first word has valid_out two cycles after its pop cycle.
- REQ-027 Counters SHALL increment on each transfer of the corresponding source and wrap from all-ones to 0.

Reset
- REQ-028 While reset = 1 at a rising edge: state = IDLE, occupancy = 0, inflight = 0, last-popped = D1 (D0 served first), counters = 0.
- REQ-029 D0_pop and D1_pop SHALL be 0 in any cycle where reset = 1; data in flight at reset SHALL be discarded.
- REQ-030 After reset: valid_out = 0, data_out = 0, dest_out = 0, cnt_D0 = cnt_D1 = 0.

Configuration
- REQ-031 Macro D_DRAIN_STATS_EN: defined -> counters implemented per REQ-027; undefined -> no counter registers, cnt_D0/cnt_D1 tied to 0.

Verification
- REQ-032 Reset held 3 cycles with active_in = 1 and both FIFOs non-empty -> no pop, valid_out = 0, counters = 0.
- REQ-033 Both FIFOs non-empty, out_ready = 1, D0 = 6'b000101, D1 = 6'b110110 -> pops alternate D0, D1, D0...; data_out alternates with dest_out 0, 1; one word per cycle.
- REQ-034 out_ready = 0 for 5 cycles with both non-empty -> exactly 2 pops, then pops stop; valid_out held, data_out stable, no word lost when out_ready returns to 1.
- REQ-035 Only D1 non-empty (4 words) -> 4 consecutive D1_pop, D0_pop never asserted, cnt_D1 = 4.
- REQ-036 active_in drops with 1 word in flight and 1 buffered -> no further pops, both words delivered, FSM reaches IDLE.
- REQ-037 With D_DRAIN_STATS_EN, 256 D0 transfers -> cnt_D0 wraps to 0; without the macro -> cnt_D0 = 0 throughout.
